// File: rtl/demux1to8_buf_if.sv
// Producer/consumer bundle for the 1:N buffered demux.
// The slave modport is the demux's view; master is the driving side (producer plus sinks).
interface demux1to8_buf_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
);
  localparam int N = 2 ** SEL_W;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux1to8_buf.sv
// Routes one producer word to one of N channels, each with a one-entry holding slot,
// so a stalled consumer only blocks writes aimed at its own channel.
module demux1to8_buf #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  demux1to8_buf_if.slave     bus,
  output logic [CNT_W-1:0]   stall_cnt
);
  // channel k state | meaning
  //   vld[k]=0      | EMPTY, slot free
  //   vld[k]=1      | FULL, slot holds a word for consumer k
  localparam int N = 2 ** SEL_W;

  logic [N-1:0]     vld;
  logic [WIDTH-1:0] slot [N];
  logic             accept;
  logic             stall;

  // A full channel frees its slot in the same cycle its consumer takes the word.
  assign bus.in_ready  = ~vld[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign bus.out_valid = vld;
  assign accept        = bus.in_valid & bus.in_ready;
  assign stall         = bus.in_valid & ~bus.in_ready;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign bus.out_data[g*WIDTH +: WIDTH] = slot[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld       <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < N; k++) begin
        slot[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (accept && (bus.in_sel == SEL_W'(k))) begin
          slot[k] <= bus.in_data;
          vld[k]  <= 1'b1;
        end else if (vld[k] && bus.out_ready[k]) begin
          vld[k]  <= 1'b0;
        end
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_demux1to8_buf.sv
// Randomized and directed bench for demux1to8_buf against an array-based channel model.
// A second instance with a 4-bit stall counter shares the stimulus to cover saturation.
module tb_demux1to8_buf;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] stall16;
  logic [3:0]  stall4;

  int n_vec = 0;
  int n_err = 0;

  demux1to8_buf_if #(.WIDTH(32), .SEL_W(3)) bus  ();
  demux1to8_buf_if #(.WIDTH(32), .SEL_W(3)) bus4 ();

  demux1to8_buf #(.WIDTH(32), .SEL_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall16)
  );
  demux1to8_buf #(.WIDTH(32), .SEL_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .stall_cnt(stall4)
  );

  always #5 clk = ~clk;

  // reference model: what each channel holds and how many blocked cycles were seen
  bit          m_vld  [8];
  logic [31:0] m_data [8];
  int          m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ch(input int k);
    return bus.out_data[k*32 +: 32];
  endfunction

  function automatic logic [7:0] m_vld_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_vld[k];
    return v;
  endfunction

  // Called just after a posedge: drive inputs, check pre-edge outputs, then advance the model.
  task automatic step(input bit v, input int s, input logic [31:0] d,
                      input logic [7:0] ordy, input bit rst);
    bit exp_ready;
    reset = rst;
    bus.in_valid  = v;    bus4.in_valid  = v;
    bus.in_sel    = 3'(s); bus4.in_sel   = 3'(s);
    bus.in_data   = d;    bus4.in_data   = d;
    bus.out_ready = ordy; bus4.out_ready = ordy;
    @(negedge clk);
    exp_ready = !m_vld[s] || ordy[s];
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_vld_vec()));
    for (int k = 0; k < 8; k++) chk($sformatf("data%0d", k), ch(k), m_data[k]);
    chk("stall16", 32'(stall16), 32'(m_stall > 65535 ? 65535 : m_stall));
    chk("stall4", 32'(stall4), 32'(m_stall > 15 ? 15 : m_stall));
    chk("out_valid4", 32'(bus4.out_valid), 32'(m_vld_vec()));
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_vld[k]  = 0;
        m_data[k] = '0;
      end
      m_stall = 0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (v && exp_ready && s == k) begin
          m_vld[k]  = 1;
          m_data[k] = d;
        end else if (m_vld[k] && ordy[k]) begin
          m_vld[k] = 0;
        end
      end
      if (v && !exp_ready) m_stall++;
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      m_vld[k]  = 0;
      m_data[k] = '0;
    end
    m_stall = 0;
    reset = 1'b1;
    bus.in_valid = 0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = '0;
    bus4.in_valid = 0; bus4.in_sel = '0; bus4.in_data = '0; bus4.out_ready = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 8'h00, 1);
    chk("rst_vld", 32'(bus.out_valid), 32'h0);
    chk("rst_stall", 32'(stall16), 32'h0);

    // single word, immediately drained
    step(1, 3, 32'hDEADBEEF, 8'hFF, 0);
    chk("t1_vld", 32'(bus.out_valid), 32'h08);
    chk("t1_d3", ch(3), 32'hDEADBEEF);
    step(0, 0, 0, 8'hFF, 0);
    chk("t1_empty", 32'(bus.out_valid), 32'h00);

    // blocked channel holds its word, stall counts, release loads the new word
    step(1, 5, 32'h11, 8'h00, 0);
    chk("t2_d5", ch(5), 32'h11);
    for (int i = 0; i < 3; i++) step(1, 5, 32'h22, 8'h00, 0);
    chk("t2_hold", ch(5), 32'h11);
    chk("t2_stall", 32'(stall16), 32'd3);
    step(1, 5, 32'h22, 8'h20, 0);
    chk("t2_d5b", ch(5), 32'h22);
    chk("t2_vld", 32'(bus.out_valid), 32'h20);
    step(0, 0, 0, 8'hFF, 0);

    // full-throughput streaming into one channel
    step(0, 0, 0, 8'h00, 1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 2, 32'(i), 8'h04, 0);
      chk("t3_d2", ch(2), 32'(i));
      chk("t3_vld", 32'(bus.out_valid), 32'h04);
    end
    chk("t3_stall", 32'(stall16), 32'd0);

    // a stalled channel does not block a different channel
    step(1, 6, 32'h66, 8'h00, 0);
    step(1, 6, 32'h77, 8'h00, 0);
    step(1, 1, 32'hA5, 8'h00, 0);
    chk("t4_d1", ch(1), 32'hA5);
    chk("t4_d6", ch(6), 32'h66);

    // reset with in_valid high flushes everything
    step(0, 0, 0, 8'h00, 1);
    step(1, 0, 32'hA0, 8'h00, 0);
    step(1, 4, 32'hA4, 8'h00, 0);
    step(1, 7, 32'hA7, 8'h00, 0);
    chk("t5_pre", 32'(bus.out_valid), 32'h91);
    step(1, 2, 32'h99, 8'h00, 1);
    chk("t5_vld", 32'(bus.out_valid), 32'h00);
    chk("t5_d7", ch(7), 32'h0);
    chk("t5_d2", ch(2), 32'h0);
    chk("t5_stall", 32'(stall16), 32'h0);

    // saturation of the narrow counter
    step(1, 0, 32'h1, 8'h00, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 32'h2, 8'h00, 0);
    chk("t6_sat4", 32'(stall4), 32'd15);
    chk("t6_cnt16", 32'(stall16), 32'd20);
    step(0, 0, 0, 8'h00, 1);

    // random traffic, sinks ready about half the time, occasional reset
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom,
           8'($urandom), $urandom_range(0, 63) == 0);
    end
    step(0, 0, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
